// File: rtl/up_control_unit_if.sv
// Control/status bundle between the accumulator-processor control unit and its datapath.
// The control unit takes the master side: it reads opcode/status and drives the strobes.
interface up_control_unit_if #(
  parameter int STATE_W = 4
);
  logic               Enter;
  logic [2:0]         IR;
  logic               Aeq0;
  logic               Apos;
  logic               IRload;
  logic               JMPmux;
  logic               PCload;
  logic               Meminst;
  logic               MemWr;
  logic               Aload;
  logic               Sub;
  logic [1:0]         Asel;
  logic               Halt;
  logic [STATE_W-1:0] State;

  modport master (
    input  Enter, IR, Aeq0, Apos,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );

  modport slave (
    output Enter, IR, Aeq0, Apos,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );
endinterface

// File: rtl/up_control_unit.sv
// Control-unit FSM for the 8-bit accumulator processor.
// Fetch / decode / execute, three cycles per instruction; IN waits for an Enter handshake.
// Optional feature macro: UCU_SINGLE_STEP_EN adds a Step input and a STEP_WAIT pause
// after every completed execute state.
// Moore strobes are registered (computed from the next state) and gated off while RESET
// is high; PCload in JZ/JPOS and Aload in INPUT additionally depend on live inputs.
module up_control_unit #(
  parameter int STATE_W    = 4,
  parameter bit ENTER_EDGE = 1'b1
) (
  input  logic CLOCK,
  input  logic RESET,
`ifdef UCU_SINGLE_STEP_EN
  input  logic Step,
`endif
  up_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    START     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    STEP_WAIT = 4'd3,
    LOAD      = 4'd8,
    STORE     = 4'd9,
    ADD       = 4'd10,
    SUB       = 4'd11,
    INPUT     = 4'd12,
    JZ        = 4'd13,
    JPOS      = 4'd14,
    HALT      = 4'd15
  } state_t;

  typedef struct packed {
    logic       irload;
    logic       jmpmux;
    logic       pcload;
    logic       meminst;
    logic       memwr;
    logic       aload;
    logic       sub;
    logic [1:0] asel;
    logic       halt;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;
  logic   enter_q;
  logic   accept;
  state_t done_next;
`ifdef UCU_SINGLE_STEP_EN
  logic   step_q;
`endif

  // State-only strobe pattern; live-input exceptions are added at the outputs.
  function automatic ctl_t moore(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.irload = 1'b1; c.pcload = 1'b1; end
      DECODE:  c.meminst = 1'b1;
      LOAD:    begin c.meminst = 1'b1; c.asel = 2'b10; c.aload = 1'b1; end
      STORE:   begin c.meminst = 1'b1; c.memwr = 1'b1; end
      ADD:     begin c.meminst = 1'b1; c.aload = 1'b1; end
      SUB:     begin c.meminst = 1'b1; c.aload = 1'b1; c.sub = 1'b1; end
      INPUT:   c.asel = 2'b01;
      JZ:      c.jmpmux = 1'b1;
      JPOS:    c.jmpmux = 1'b1;
      HALT:    c.halt = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection, including the IN accept condition and the post-execute target.
  always_comb begin
    accept = ENTER_EDGE ? (bus.Enter & ~enter_q) : bus.Enter;
`ifdef UCU_SINGLE_STEP_EN
    done_next = STEP_WAIT;
`else
    done_next = FETCH;
`endif
    nxt = START;
    case (state)
      START:  nxt = FETCH;
      FETCH:  nxt = DECODE;
      // Execute codes are 8 + opcode, so decode is a direct map.
      DECODE: nxt = state_t'({1'b1, bus.IR});
      LOAD, STORE, ADD, SUB, JZ, JPOS: nxt = done_next;
      INPUT:  nxt = accept ? done_next : INPUT;
      HALT:   nxt = HALT;
`ifdef UCU_SINGLE_STEP_EN
      STEP_WAIT: nxt = (Step & ~step_q) ? FETCH : STEP_WAIT;
`else
      STEP_WAIT: nxt = FETCH;
`endif
      default: nxt = START;
    endcase
  end

  // State register, registered Moore strobes and edge-detect history.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= START;
      ctl_q   <= moore(START);
      enter_q <= 1'b0;
`ifdef UCU_SINGLE_STEP_EN
      step_q  <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      ctl_q   <= moore(nxt);
      enter_q <= bus.Enter;
`ifdef UCU_SINGLE_STEP_EN
      step_q  <= Step;
`endif
    end
  end

  // Output stage: reset blanks every strobe so a mid-instruction reset never writes RAM.
  assign bus.IRload  = ~RESET & ctl_q.irload;
  assign bus.JMPmux  = ~RESET & ctl_q.jmpmux;
  assign bus.PCload  = ~RESET & (ctl_q.pcload |
                                 ((state == JZ)   & bus.Aeq0) |
                                 ((state == JPOS) & bus.Apos));
  assign bus.Meminst = ~RESET & ctl_q.meminst;
  assign bus.MemWr   = ~RESET & ctl_q.memwr;
  assign bus.Aload   = ~RESET & (ctl_q.aload | ((state == INPUT) & accept));
  assign bus.Sub     = ~RESET & ctl_q.sub;
  assign bus.Asel    = RESET ? 2'b00 : ctl_q.asel;
  assign bus.Halt    = ~RESET & ctl_q.halt;
  assign bus.State   = STATE_W'(state);

endmodule

// File: tb/tb_up_control_unit.sv
// Bench for up_control_unit: a small behavioural datapath (IR, A, PC, 32x8 RAM) runs
// directed programs under the control unit; expected values are hand-derived.
module tb_up_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef UCU_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  always #5 clk = ~clk;

  up_control_unit_if #(.STATE_W(4)) bus ();

`ifdef UCU_SINGLE_STEP_EN
  up_control_unit #(.STATE_W(4), .ENTER_EDGE(1'b1)) dut (
    .CLOCK(clk), .RESET(rst), .Step(step), .bus(bus));
`else
  up_control_unit #(.STATE_W(4), .ENTER_EDGE(1'b1)) dut (
    .CLOCK(clk), .RESET(rst), .bus(bus));
`endif

  // Behavioural datapath
  logic [7:0] ram [32];
  logic [7:0] ram_init [32];
  logic [7:0] ir, a, a_init, in_byte;
  logic [4:0] pc;
  logic [4:0] addr;
  logic       load_dp = 1'b0;

  assign addr     = bus.Meminst ? ir[4:0] : pc;
  assign bus.IR   = ir[7:5];
  assign bus.Aeq0 = (a == 8'd0);
  assign bus.Apos = ~a[7];

  always @(posedge clk) begin
    if (load_dp) begin
      ram <= ram_init;
      a   <= a_init;
      pc  <= 5'd0;
      ir  <= 8'd0;
    end else begin
      if (bus.IRload) ir <= ram[addr];
      if (bus.PCload) pc <= bus.JMPmux ? ir[4:0] : pc + 5'd1;
      if (bus.Aload)
        a <= bus.Asel[1] ? ram[addr] :
             (bus.Asel[0] ? in_byte : (bus.Sub ? a - ram[addr] : a + ram[addr]));
      if (bus.MemWr) ram[addr] <= a;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) ram_init[i] = 8'd0;
    a_init = 8'd0;
  endtask

  // Reset with datapath preload; returns #1 into the START cycle (cycle 0).
  task automatic reset_cpu();
    rst = 1'b1;
    load_dp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_dp = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bus.Enter = 1'b0;
    in_byte   = 8'h3C;

    // Reset sequence START -> FETCH -> DECODE
    clear_prog();
    reset_cpu();
    check("t1_state0", bus.State, 0);
    check("t1_irload0", bus.IRload, 0);
    cyc(1);
    check("t1_state1", bus.State, 1);
    check("t1_fetch_strobes", {bus.IRload, bus.PCload, bus.Meminst, bus.JMPmux}, 4'b1100);
    cyc(1);
    check("t1_state2", bus.State, 2);
    check("t1_decode_strobes", {bus.IRload, bus.PCload, bus.Meminst}, 3'b001);

    // LOAD 30, ADD 31, STORE 29, HALT
    clear_prog();
    ram_init[0] = 8'h1E; ram_init[1] = 8'h5F; ram_init[2] = 8'h3D; ram_init[3] = 8'hE0;
    ram_init[30] = 8'd5; ram_init[31] = 8'd7;
    reset_cpu();
    cyc(3);
    check("t2_load_state", bus.State, 8);
    check("t2_load_asel", {bus.Aload, bus.Asel, bus.Meminst}, 4'b1101);
    cyc(8);
    check("t2_halt_early", bus.Halt, 0);
    cyc(1);
    check("t2_halt", bus.Halt, 1);
    check("t2_halt_state", bus.State, 15);
    check("t2_ram29", ram[29], 12);
    check("t2_a", a, 12);
    cyc(3);
    check("t2_halt_hold", {bus.State, bus.Halt}, {4'd15, 1'b1});
    check("t2_halt_quiet", {bus.IRload, bus.PCload, bus.MemWr, bus.Aload}, 4'b0000);
    check("t2_pc", pc, 4);

    // LOAD 31, SUB 30 -> 7-5
    clear_prog();
    ram_init[0] = 8'h1F; ram_init[1] = 8'h7E; ram_init[2] = 8'hE0;
    ram_init[30] = 8'd5; ram_init[31] = 8'd7;
    reset_cpu();
    cyc(6);
    check("t2_sub_state", bus.State, 11);
    check("t2_sub_strobe", {bus.Sub, bus.Aload, bus.Asel}, 4'b1100);
    cyc(1);
    check("t2_sub_a", a, 2);

    // IN with Enter held beforehand, then a fresh rising edge
    clear_prog();
    ram_init[0] = 8'h80; ram_init[1] = 8'hE0;
    bus.Enter = 1'b1;
    reset_cpu();
    cyc(3);
    check("t3_in_state", bus.State, 12);
    check("t3_in_noload", {bus.Aload, bus.Asel}, 3'b001);
    cyc(2);
    check("t3_in_wait", {bus.State, bus.Aload}, {4'd12, 1'b0});
    bus.Enter = 1'b0;
    cyc(1);
    check("t3_in_low", {bus.State, bus.Aload}, {4'd12, 1'b0});
    bus.Enter = 1'b1;
    #1;
    check("t3_accept", {bus.Aload, bus.Asel}, 3'b101);
    cyc(1);
    check("t3_after_state", bus.State, 1);
    check("t3_after_noload", bus.Aload, 0);
    check("t3_a_input", a, 8'h3C);
    bus.Enter = 1'b0;

    // JZ 5 with A=0 jumps
    clear_prog();
    ram_init[0] = 8'hA5;
    reset_cpu();
    cyc(3);
    check("t4_jz_state", bus.State, 13);
    check("t4_jz_take", {bus.PCload, bus.JMPmux}, 2'b11);
    cyc(1);
    check("t4_jz_pc", pc, 5);
    check("t4_jz_next", bus.State, 1);

    // JZ 5 with A=3 falls through
    a_init = 8'd3;
    reset_cpu();
    cyc(3);
    check("t4_jz_nz", {bus.PCload, bus.JMPmux}, 2'b01);
    cyc(1);
    check("t4_jz_nz_pc", pc, 1);

    // JPOS 5 with A=0x80 falls through, A=0x01 jumps
    ram_init[0] = 8'hC5;
    a_init = 8'h80;
    reset_cpu();
    cyc(3);
    check("t4_jpos_state", bus.State, 14);
    check("t4_jpos_neg", bus.PCload, 0);
    cyc(1);
    check("t4_jpos_neg_pc", pc, 1);
    a_init = 8'h01;
    reset_cpu();
    cyc(4);
    check("t4_jpos_pos_pc", pc, 5);

    // Reset asserted during STORE blanks MemWr
    clear_prog();
    ram_init[0] = 8'h3D;
    a_init = 8'h55;
    reset_cpu();
    cyc(3);
    check("t5_store_state", bus.State, 9);
    check("t5_store_wr", bus.MemWr, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_blank", {bus.MemWr, bus.Meminst, bus.Halt, bus.Aload}, 4'b0000);
    cyc(1);
    check("t5_rst_state", bus.State, 0);
    check("t5_ram_kept", ram[29], 0);
    rst = 1'b0;

    // LOAD, LOAD, HALT: free-running or single-stepped
    clear_prog();
    ram_init[0] = 8'h1E; ram_init[1] = 8'h1F; ram_init[2] = 8'hE0;
    ram_init[30] = 8'd5; ram_init[31] = 8'd9;
    reset_cpu();
    cyc(4);
`ifdef UCU_SINGLE_STEP_EN
    check("t6_step_wait", bus.State, 3);
    check("t6_a", a, 5);
    cyc(2);
    check("t6_step_hold", bus.State, 3);
    step = 1'b1;
    cyc(1);
    check("t6_step_fetch", bus.State, 1);
    cyc(3);
    check("t6_second_wait", bus.State, 3);
    cyc(3);
    check("t6_held_no_adv", bus.State, 3);
    step = 1'b0;
    cyc(1);
    step = 1'b1;
    cyc(1);
    check("t6_restep", bus.State, 1);
    step = 1'b0;
`else
    check("t6_free_run", bus.State, 1);
    check("t6_a", a, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
